// File: rtl/map_arb_pkg.sv
// ---------------------------------------------------------------------------
// map_arb_pkg
//   Shared definitions for the map ROM arbiter: default ROM geometry, the
//   owner tag encoding carried alongside each read through the ROM pipeline,
//   and small width helpers.
//
//   Owner tags: OWNER_NONE (no read in flight), OWNER_SCAN (scanout read),
//   OWNER_P0 + i (read issued for probe i). Tag width is $clog2(N_PROBE+2).
// ---------------------------------------------------------------------------
package map_arb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 8;

    localparam int OWNER_NONE = 0;
    localparam int OWNER_SCAN = 1;
    localparam int OWNER_P0   = 2;

    // Who owns the ROM slot in the current cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_SCAN,
        SLOT_PROBE
    } slot_e;

    function automatic int ownerTagWidth(input int nProbe);
        return $clog2(nProbe + 2);
    endfunction

    // A single probe still needs a one-bit index/pointer.
    function automatic int probeIdxWidth(input int nProbe);
        return (nProbe > 1) ? $clog2(nProbe) : 1;
    endfunction

endpackage

// File: rtl/map_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// map_arb_rr_pick
//   Combinational round-robin picker. Chooses the first requester strictly
//   after the pointer position, wrapping around to index 0.
//
//   Ports:
//     req_i    in   N        request vector
//     ptr_i    in   IDX_W    index of the most recent winner
//     gnt_o    out  N        one-hot grant (zero when nothing requests)
//     idx_o    out  IDX_W    index of the granted requester
//     valid_o  out  1        at least one request present
// ---------------------------------------------------------------------------
module map_arb_rr_pick
    import map_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = probeIdxWidth(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [N-1:0] aboveMask;
    logic [N-1:0] maskedReq;

    // Requests above the pointer take precedence; if none, fall back to the
    // lowest request overall (the wrap-around case). The downward scan leaves
    // the lowest qualifying index as the final assignment.
    always_comb begin
        aboveMask = '0;
        for (int i = 0; i < N; i++) begin
            aboveMask[i] = (IDX_W'(i) > ptr_i);
        end
        maskedReq = req_i & aboveMask;
        gnt_o     = '0;
        idx_o     = '0;
        valid_o   = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (maskedReq[i] || ((maskedReq == '0) && req_i[i])) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/map_rom_arbiter.sv
// ---------------------------------------------------------------------------
// map_rom_arbiter
//   Owns the address port of the single-port synchronous map ROM and shares
//   it between VGA scanout (absolute priority, never stalled) and N_PROBE
//   collision probes served round-robin in scan-idle cycles. Each read's
//   owner tag travels through a 1+ROM_LAT deep pipeline so returning data is
//   steered to the right consumer; results appear 2+ROM_LAT cycles after the
//   request/grant cycle, in order, one per cycle.
//
//   Optional feature macro: MAP_ARB_TIMEOUT_EN adds per-probe starvation
//   counters and the probe_timeout_o port.
//
//   Ports:
//     clk_25m_i        in   1               pixel clock
//     rst_i            in   1               async active-high reset
//     scan_req_i       in   1               scanout needs the ROM this cycle
//     scan_addr_i      in   ADDR_W          scanout address
//     scan_valid_o     out  1               scan_data_o valid
//     scan_data_o      out  DATA_W          scanout pixel
//     probe_req_i      in   N_PROBE         per-probe request
//     probe_addr_i     in   N_PROBE*ADDR_W  packed probe addresses
//     probe_gnt_o      out  N_PROBE         one-hot combinational grant
//     probe_rvalid_o   out  N_PROBE         one-hot read-data valid
//     probe_rdata_o    out  DATA_W          shared probe read data
//     rom_en_o         out  1               ROM enable (registered)
//     rom_addr_o       out  ADDR_W          ROM address (registered)
//     rom_data_i       in   DATA_W          ROM read data
//     probe_timeout_o  out  N_PROBE         starvation pulse (MAP_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module map_rom_arbiter
    import map_arb_pkg::*;
#(
    parameter int N_PROBE  = 4,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 1024
) (
    input  logic                      clk_25m_i,
    input  logic                      rst_i,
    input  logic                      scan_req_i,
    input  logic [ADDR_W-1:0]         scan_addr_i,
    output logic                      scan_valid_o,
    output logic [DATA_W-1:0]         scan_data_o,
    input  logic [N_PROBE-1:0]        probe_req_i,
    input  logic [N_PROBE*ADDR_W-1:0] probe_addr_i,
    output logic [N_PROBE-1:0]        probe_gnt_o,
    output logic [N_PROBE-1:0]        probe_rvalid_o,
    output logic [DATA_W-1:0]         probe_rdata_o,
    output logic                      rom_en_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i
`ifdef MAP_ARB_TIMEOUT_EN
    ,
    output logic [N_PROBE-1:0]        probe_timeout_o
`endif
);

    localparam int TAG_W = ownerTagWidth(N_PROBE);
    localparam int IDX_W = probeIdxWidth(N_PROBE);

    slot_e              slot;
    logic [N_PROBE-1:0] pickGnt;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickValid;
    logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
    logic               romEn_q, romEn_d;
    logic [ADDR_W-1:0]  romAddr_q, romAddr_d;
    logic [TAG_W-1:0]   tagIn;
    logic [TAG_W-1:0]   tagPipe_q [ROM_LAT+1];
    logic [TAG_W-1:0]   tail;
    logic [ADDR_W-1:0]  probeAddr [N_PROBE];
    logic               scanValid_q, scanValid_d;
    logic [DATA_W-1:0]  scanData_q, scanData_d;
    logic [N_PROBE-1:0] probeRvalid_q, probeRvalid_d;
    logic [DATA_W-1:0]  probeRdata_q, probeRdata_d;

    map_arb_rr_pick #(
        .N     (N_PROBE),
        .IDX_W (IDX_W)
    ) u_rrPick (
        .req_i   (probe_req_i),
        .ptr_i   (rrPtr_q),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    // Unpack the flat probe address bus.
    always_comb begin
        for (int i = 0; i < N_PROBE; i++) begin
            probeAddr[i] = probe_addr_i[i*ADDR_W +: ADDR_W];
        end
    end

    // Scanout always wins the slot; probes only compete when scan is idle.
    always_comb begin
        slot = SLOT_IDLE;
        if (scan_req_i) begin
            slot = SLOT_SCAN;
        end else if (pickValid) begin
            slot = SLOT_PROBE;
        end
    end

    // Slot issue: ROM command, pointer advance and owner tag for the read.
    always_comb begin
        probe_gnt_o = '0;
        rrPtr_d     = rrPtr_q;
        romEn_d     = 1'b0;
        romAddr_d   = romAddr_q;
        tagIn       = TAG_W'(OWNER_NONE);
        case (slot)
            SLOT_SCAN: begin
                romEn_d   = 1'b1;
                romAddr_d = scan_addr_i;
                tagIn     = TAG_W'(OWNER_SCAN);
            end
            SLOT_PROBE: begin
                probe_gnt_o = pickGnt;
                rrPtr_d     = pickIdx;
                romEn_d     = 1'b1;
                romAddr_d   = probeAddr[pickIdx];
                tagIn       = TAG_W'(OWNER_P0) + TAG_W'(pickIdx);
            end
            default: ;
        endcase
    end

    // Output steering from the pipeline tail; data registers hold when idle.
    always_comb begin
        tail          = tagPipe_q[ROM_LAT];
        scanValid_d   = 1'b0;
        scanData_d    = scanData_q;
        probeRvalid_d = '0;
        probeRdata_d  = probeRdata_q;
        if (tail == TAG_W'(OWNER_SCAN)) begin
            scanValid_d = 1'b1;
            scanData_d  = rom_data_i;
        end
        for (int i = 0; i < N_PROBE; i++) begin
            if (tail == TAG_W'(OWNER_P0 + i)) begin
                probeRvalid_d[i] = 1'b1;
                probeRdata_d     = rom_data_i;
            end
        end
    end

    // Pointer resets to the last probe so probe 0 wins first. Reset also
    // flushes in-flight owner tags so no stale results are delivered.
    always_ff @(posedge clk_25m_i or posedge rst_i) begin
        if (rst_i) begin
            rrPtr_q       <= IDX_W'(N_PROBE - 1);
            romEn_q       <= 1'b0;
            romAddr_q     <= '0;
            for (int s = 0; s <= ROM_LAT; s++) begin
                tagPipe_q[s] <= TAG_W'(OWNER_NONE);
            end
            scanValid_q   <= 1'b0;
            scanData_q    <= '0;
            probeRvalid_q <= '0;
            probeRdata_q  <= '0;
        end else begin
            rrPtr_q       <= rrPtr_d;
            romEn_q       <= romEn_d;
            romAddr_q     <= romAddr_d;
            tagPipe_q[0]  <= tagIn;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tagPipe_q[s] <= tagPipe_q[s-1];
            end
            scanValid_q   <= scanValid_d;
            scanData_q    <= scanData_d;
            probeRvalid_q <= probeRvalid_d;
            probeRdata_q  <= probeRdata_d;
        end
    end

    assign rom_en_o       = romEn_q;
    assign rom_addr_o     = romAddr_q;
    assign scan_valid_o   = scanValid_q;
    assign scan_data_o    = scanData_q;
    assign probe_rvalid_o = probeRvalid_q;
    assign probe_rdata_o  = probeRdata_q;

`ifdef MAP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]   waitCnt_q [N_PROBE];
    logic [CNT_W-1:0]   waitCnt_d [N_PROBE];
    logic [N_PROBE-1:0] timeout_q, timeout_d;

    // A probe is starving while it requests without a grant. The counter
    // saturates at MAX_WAIT so the pulse fires exactly once per wait episode.
    always_comb begin
        timeout_d = '0;
        for (int i = 0; i < N_PROBE; i++) begin
            waitCnt_d[i] = '0;
            if (probe_req_i[i] && !probe_gnt_o[i]) begin
                waitCnt_d[i] = (waitCnt_q[i] == CNT_W'(MAX_WAIT)) ?
                               waitCnt_q[i] : waitCnt_q[i] + CNT_W'(1);
                timeout_d[i] = (waitCnt_q[i] == CNT_W'(MAX_WAIT - 1));
            end
        end
    end

    always_ff @(posedge clk_25m_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_PROBE; i++) begin
                waitCnt_q[i] <= '0;
            end
            timeout_q <= '0;
        end else begin
            for (int i = 0; i < N_PROBE; i++) begin
                waitCnt_q[i] <= waitCnt_d[i];
            end
            timeout_q <= timeout_d;
        end
    end

    assign probe_timeout_o = timeout_q;
`else
    logic unused_maxWait;
    assign unused_maxWait = ^MAX_WAIT;
`endif

endmodule

// File: tb/tb_map_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_map_rom_arbiter
//   Directed bench for map_rom_arbiter with a behavioural ROM, a reference
//   round-robin model and an in-order scoreboard of expected read results.
// ---------------------------------------------------------------------------
module tb_map_rom_arbiter;

    localparam int N   = 4;
    localparam int AW  = 19;
    localparam int DW  = 8;
    localparam int LAT = 1;
    localparam int MW  = 8;

    typedef struct {
        int             owner;
        logic [DW-1:0]  data;
        int             due;
    } scb_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            scan_req;
    logic [AW-1:0]   scan_addr;
    logic            scan_valid;
    logic [DW-1:0]   scan_data;
    logic [N-1:0]    probe_req;
    logic [N*AW-1:0] probe_addr;
    logic [N-1:0]    probe_gnt;
    logic [N-1:0]    probe_rvalid;
    logic [DW-1:0]   probe_rdata;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
`ifdef MAP_ARB_TIMEOUT_EN
    logic [N-1:0]    probe_timeout;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    scb_t sb[$];

    int            tbPtr   = N - 1;
    logic          expEn   = 1'b0;
    logic [AW-1:0] expAddr = '0;
`ifdef MAP_ARB_TIMEOUT_EN
    int            tbWait [N];
    logic [N-1:0]  expTo   = '0;
    int            toPulses = 0;
`endif

    map_rom_arbiter #(
        .N_PROBE  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .ROM_LAT  (LAT),
        .MAX_WAIT (MW)
    ) dut (
        .clk_25m_i       (clk),
        .rst_i           (rst),
        .scan_req_i      (scan_req),
        .scan_addr_i     (scan_addr),
        .scan_valid_o    (scan_valid),
        .scan_data_o     (scan_data),
        .probe_req_i     (probe_req),
        .probe_addr_i    (probe_addr),
        .probe_gnt_o     (probe_gnt),
        .probe_rvalid_o  (probe_rvalid),
        .probe_rdata_o   (probe_rdata),
        .rom_en_o        (rom_en),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data)
`ifdef MAP_ARB_TIMEOUT_EN
        ,
        .probe_timeout_o (probe_timeout)
`endif
    );

    always #20 clk = ~clk;

    // Pixel content is a scrambled function of the address so every read is
    // distinguishable; disabled cycles produce a junk value.
    function automatic logic [DW-1:0] romVal(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
    endfunction

    logic [DW-1:0] romPipe [LAT];
    always @(posedge clk) begin
        romPipe[0] <= rom_en ? romVal(rom_addr) : 8'hEE;
        for (int k = 1; k < LAT; k++) begin
            romPipe[k] <= romPipe[k-1];
        end
    end
    assign rom_data = romPipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: check registered outputs against the model, then
    // predict this cycle's arbitration and queue the expected read result.
    always @(negedge clk) begin
        logic [N-1:0]  expGnt;
        logic [N-1:0]  nextTo;
        logic [DW-1:0] obsData;
        int            basePtr;
        int            obsOwner;
        int            k;
        scb_t          e;
        if (rst) begin
            sb.delete();
            tbPtr   = N - 1;
            expEn   = 1'b0;
            expAddr = '0;
            checkOutput("rstRomEn",     32'(rom_en),       32'(0));
            checkOutput("rstRomAddr",   32'(rom_addr),     32'(0));
            checkOutput("rstScanValid", 32'(scan_valid),   32'(0));
            checkOutput("rstScanData",  32'(scan_data),    32'(0));
            checkOutput("rstRvalid",    32'(probe_rvalid), 32'(0));
            checkOutput("rstRdata",     32'(probe_rdata),  32'(0));
`ifdef MAP_ARB_TIMEOUT_EN
            for (int i = 0; i < N; i++) tbWait[i] = 0;
            expTo = '0;
            checkOutput("rstTimeout",   32'(probe_timeout), 32'(0));
`endif
        end else begin
            checkOutput("romEn",   32'(rom_en),   32'(expEn));
            checkOutput("romAddr", 32'(rom_addr), 32'(expAddr));
            checkOutput("oneValidMax", 32'($countones({scan_valid, probe_rvalid})) <= 1 ? 32'(1) : 32'(0), 32'(1));

            if (scan_valid || (probe_rvalid != '0)) begin
                obsOwner = 1;
                obsData  = scan_data;
                if (!scan_valid) begin
                    obsData = probe_rdata;
                    for (int i = 0; i < N; i++) if (probe_rvalid[i]) obsOwner = 2 + i;
                end
                if (sb.size() == 0) begin
                    checkOutput("spuriousValid", 32'(obsOwner), 32'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("owner", 32'(obsOwner), 32'(e.owner));
                    checkOutput("data",  32'(obsData),  32'(e.data));
                    checkOutput("due",   32'(cyc),      32'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput("validAtDue", 32'(scan_valid) + 32'(|probe_rvalid), 32'(1));
            end

`ifdef MAP_ARB_TIMEOUT_EN
            checkOutput("timeout", 32'(probe_timeout), 32'(expTo));
            if (probe_timeout[0]) toPulses++;
`endif

            expGnt = '0;
            if (scan_req) begin
                sb.push_back('{owner: 1, data: romVal(scan_addr), due: cyc + 2 + LAT});
                expEn   = 1'b1;
                expAddr = scan_addr;
            end else begin
                expEn   = 1'b0;
                basePtr = tbPtr;
                for (int j = 1; j <= N; j++) begin
                    k = (basePtr + j) % N;
                    if (probe_req[k] && expGnt == '0) begin
                        expGnt[k] = 1'b1;
                        tbPtr     = k;
                        expEn     = 1'b1;
                        expAddr   = probe_addr[k*AW +: AW];
                        sb.push_back('{owner: 2 + k, data: romVal(probe_addr[k*AW +: AW]), due: cyc + 2 + LAT});
                    end
                end
            end
            checkOutput("gnt", 32'(probe_gnt), 32'(expGnt));

`ifdef MAP_ARB_TIMEOUT_EN
            nextTo = '0;
            for (int i = 0; i < N; i++) begin
                if (probe_req[i] && !expGnt[i]) begin
                    if (tbWait[i] == MW - 1) nextTo[i] = 1'b1;
                    if (tbWait[i] < MW) tbWait[i]++;
                end else begin
                    tbWait[i] = 0;
                end
            end
            expTo = nextTo;
`else
            nextTo = '0;
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        scan_req   = 1'b0;
        scan_addr  = '0;
        probe_req  = '0;
        probe_addr = '0;

        // Reset, then idle with no requests.
        applyStimulus(3);
        rst = 1'b0;
        applyStimulus(10);

        // Continuous scanout, one new address per cycle.
        for (int k = 0; k < 16; k++) begin
            scan_req  = 1'b1;
            scan_addr = AW'(k);
            applyStimulus(1);
        end
        scan_req = 1'b0;
        applyStimulus(6);

        // Probe 0 blocked by scan, then served once scan drops.
        probe_req[0]         = 1'b1;
        probe_addr[0*AW +: AW] = 19'h12345;
        for (int k = 0; k < 5; k++) begin
            scan_req  = 1'b1;
            scan_addr = AW'(19'h40000 + k);
            applyStimulus(1);
        end
        scan_req = 1'b0;
        applyStimulus(1);
        probe_req = '0;
        applyStimulus(6);

        // All probes request continuously: round-robin rotation.
        for (int i = 0; i < N; i++) probe_addr[i*AW +: AW] = AW'(19'h01000 * (i + 1) + 19'h00077);
        probe_req = '1;
        applyStimulus(6);
        probe_req = '0;
        applyStimulus(6);

        // Alternating scan with probe 2 waiting for the gaps.
        probe_addr[2*AW +: AW] = 19'h7ABCD;
        probe_req[2]           = 1'b1;
        for (int k = 0; k < 10; k++) begin
            scan_req  = (k % 2 == 0);
            scan_addr = AW'(19'h00200 + k);
            probe_addr[2*AW +: AW] = AW'(19'h7ABC0 + k);
            applyStimulus(1);
        end
        scan_req  = 1'b0;
        probe_req = '0;
        applyStimulus(6);

        // Reset one cycle after a probe grant discards the in-flight read.
        probe_addr[1*AW +: AW] = 19'h55555;
        probe_req[1]           = 1'b1;
        applyStimulus(1);
        rst       = 1'b1;
        probe_req = '0;
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(8);

`ifdef MAP_ARB_TIMEOUT_EN
        // Probe 0 starved by a long scan burst.
        probe_addr[0*AW +: AW] = 19'h00ABC;
        probe_req[0]           = 1'b1;
        for (int k = 0; k < 12; k++) begin
            scan_req  = 1'b1;
            scan_addr = AW'(19'h00300 + k);
            applyStimulus(1);
        end
        scan_req = 1'b0;
        applyStimulus(1);
        probe_req = '0;
        applyStimulus(6);
        checkOutput("timeoutPulses", 32'(toPulses), 32'(1));
`endif

        checkOutput("scoreboardEmpty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
